// File: rtl/axi_reg_bank.sv
// Register bank on the 14-bit req/ack register bus. Each register is RW, RO (hardware status) or
// W1C (sticky event). The bank adds byte strobes, error responses, write pulses and an irq.
module axi_reg_bank #(
    parameter logic [6:0]   BASE_ADDRESS = 7'h10,
    parameter int unsigned  NUM_REGS     = 8,
    parameter logic [127:0] RO_MASK      = 128'h0C0,
    parameter logic [127:0] W1C_MASK     = 128'h020,
    parameter logic [31:0]  RESET_VALUE  = 32'h0
) (
    input  logic                     axi_clk,
    input  logic                     axi_rstn,
    input  logic                     axi_wreq,
    input  logic [13:0]              axi_waddr,
    input  logic [31:0]              axi_wdata,
    input  logic [3:0]               axi_wstrb,
    output logic                     axi_wack,
    output logic                     axi_werr,
    input  logic                     axi_rreq,
    input  logic [13:0]              axi_raddr,
    output logic [31:0]              axi_rdata,
    output logic                     axi_rack,
    output logic                     axi_rerr,
    input  logic [NUM_REGS*32-1:0]   hw_status,
    input  logic [NUM_REGS*32-1:0]   hw_set,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    output logic                     irq
);

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

    logic        wack_q, wack_d;
    logic        werr_q, werr_d;
    logic        rack_q, rack_d;
    logic        rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic        w_sel;
    logic [6:0]  w_off;
    logic        w_in_range;
    logic        w_ro;
    logic        w_ok;
    logic [31:0] w_byte_mask;

    assign w_sel       = axi_wreq && (axi_waddr[13:7] == BASE_ADDRESS);
    assign w_off       = axi_waddr[6:0];
    assign w_in_range  = ({1'b0, w_off} < 8'(NUM_REGS));
    assign w_ro        = w_in_range && RO_MASK[w_off];
    assign w_ok        = w_sel && w_in_range && !w_ro;
    assign w_byte_mask = {{8{axi_wstrb[3]}}, {8{axi_wstrb[2]}},
                          {8{axi_wstrb[1]}}, {8{axi_wstrb[0]}}};

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    logic       r_sel;
    logic [6:0] r_off;
    logic       r_in_range;

    assign r_sel      = axi_rreq && (axi_raddr[13:7] == BASE_ADDRESS);
    assign r_off      = axi_raddr[6:0];
    assign r_in_range = ({1'b0, r_off} < 8'(NUM_REGS));

    // ------------------------------------------------------------------
    // Register next state
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (RO_MASK[i]) begin
                regs_d[i] = 32'h0;
            end else if (W1C_MASK[i]) begin
                // Hardware set is OR-ed in after the clear so a same-cycle set wins.
                if (w_ok && (w_off == 7'(i))) begin
                    regs_d[i] = regs_q[i] & ~(axi_wdata & w_byte_mask);
                end
                regs_d[i] = regs_d[i] | hw_set[32*i +: 32];
            end else if (w_ok && (w_off == 7'(i))) begin
                regs_d[i] = (regs_q[i] & ~w_byte_mask) | (axi_wdata & w_byte_mask);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response and pulse next state
    // ------------------------------------------------------------------
    always_comb begin
        wack_d     = w_sel;
        werr_d     = w_sel && (!w_in_range || w_ro);
        wr_pulse_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_ok && (w_off == 7'(i))) begin
                wr_pulse_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rack_d  = r_sel;
        rerr_d  = r_sel && !r_in_range;
        rdata_d = 32'h0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (r_sel && (r_off == 7'(i))) begin
                rdata_d = RO_MASK[i] ? hw_status[32*i +: 32] : regs_q[i];
            end
        end
    end

    // irq follows the stored W1C bits, so it lags a storage change by one cycle.
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (W1C_MASK[i] && !RO_MASK[i] && (regs_q[i] != 32'h0)) begin
                irq_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= (RO_MASK[i] || W1C_MASK[i]) ? 32'h0 : RESET_VALUE;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wack_q     <= 1'b0;
            werr_q     <= 1'b0;
            rack_q     <= 1'b0;
            rerr_q     <= 1'b0;
            rdata_q    <= 32'h0;
            irq_q      <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            wack_q     <= wack_d;
            werr_q     <= werr_d;
            rack_q     <= rack_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Slices of hw_status/hw_set for register kinds that ignore them are intentionally dropped.
    logic unused_hw_inputs;
    assign unused_hw_inputs = ^{hw_status, hw_set};

    assign axi_wack     = wack_q;
    assign axi_werr     = werr_q;
    assign axi_rack     = rack_q;
    assign axi_rerr     = rerr_q;
    assign axi_rdata    = rdata_q;
    assign irq          = irq_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_out      = regs_q;

endmodule

// File: tb/tb_axi_reg_bank.sv
// Scoreboard bench for axi_reg_bank: the driver pushes expected responses from a behavioural
// register model; an independent monitor pops and compares whenever the DUT acknowledges.
module tb_axi_reg_bank;

    localparam logic [6:0] BASE = 7'h10;
    localparam int NREGS = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         wreq = 1'b0;
    logic [13:0]  waddr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wack, werr;
    logic         rreq = 1'b0;
    logic [13:0]  raddr = '0;
    logic [31:0]  rdata;
    logic         rack, rerr;
    logic [255:0] hs = '0;
    logic [255:0] hset = '0;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic         irq;

    axi_reg_bank dut (
        .axi_clk      (clk),
        .axi_rstn     (rstn),
        .axi_wreq     (wreq),
        .axi_waddr    (waddr),
        .axi_wdata    (wdata),
        .axi_wstrb    (wstrb),
        .axi_wack     (wack),
        .axi_werr     (werr),
        .axi_rreq     (rreq),
        .axi_raddr    (raddr),
        .axi_rdata    (rdata),
        .axi_rack     (rack),
        .axi_rerr     (rerr),
        .hw_status    (hs),
        .hw_set       (hset),
        .reg_out      (reg_out),
        .reg_wr_pulse (wr_pulse),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] data;
        logic [7:0]  pulse;
    } rsp_t;

    typedef struct {
        int unsigned  due;
        logic         irq;
        logic [255:0] regs;
    } st_t;

    rsp_t wq[$];
    rsp_t rq[$];
    st_t  sq[$];

    int n_tests = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    // Reference model: register contents by index, typed by the masks below.
    logic [31:0]  m[NREGS];
    logic [127:0] ro_v  = 128'h0C0;
    logic [127:0] w1c_v = 128'h020;
    logic [255:0] n_hs = '0;
    logic [255:0] n_hset = '0;

    function automatic logic is_ro(int i);
        return ro_v[i];
    endfunction

    function automatic logic is_w1c(int i);
        return w1c_v[i] && !ro_v[i];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m[i] = 32'h0;
        wq.delete();
        rq.delete();
        sq.delete();
    endtask

    // One bus cycle: drive at the falling edge, predict what the next rising edge produces.
    task automatic drive_cycle(input logic dw, input logic [13:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic dr, input logic [13:0] ra);
        rsp_t        e;
        st_t         s;
        logic        irq_before;
        logic [31:0] bm;
        int          off;
        @(negedge clk);
        wreq  = dw;
        waddr = wa;
        wdata = wd;
        wstrb = ws;
        rreq  = dr;
        raddr = ra;
        hs    = n_hs;
        hset  = n_hset;
        n_hset = '0;

        irq_before = 1'b0;
        for (int i = 0; i < NREGS; i++) if (is_w1c(i) && m[i] != 0) irq_before = 1'b1;

        if (dr && ra[13:7] == BASE) begin
            off = int'(ra[6:0]);
            e.due = cyc + 1;
            e.pulse = '0;
            if (off >= NREGS) begin
                e.err = 1'b1; e.data = 32'h0;
            end else if (is_ro(off)) begin
                e.err = 1'b0; e.data = hs[32*off +: 32];
            end else begin
                e.err = 1'b0; e.data = m[off];
            end
            rq.push_back(e);
        end

        if (dw && wa[13:7] == BASE) begin
            off = int'(wa[6:0]);
            e.due = cyc + 1;
            e.data = 32'h0;
            if (off >= NREGS || is_ro(off)) begin
                e.err = 1'b1; e.pulse = '0;
            end else begin
                e.err = 1'b0;
                e.pulse = 8'(1) << off;
                bm = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
                if (is_w1c(off)) m[off] = m[off] & ~(wd & bm);
                else             m[off] = (m[off] & ~bm) | (wd & bm);
            end
            wq.push_back(e);
        end

        for (int i = 0; i < NREGS; i++) if (is_w1c(i)) m[i] = m[i] | hset[32*i +: 32];

        s.due = cyc + 1;
        s.irq = irq_before;
        s.regs = '0;
        for (int i = 0; i < NREGS; i++) s.regs[32*i +: 32] = m[i];
        sq.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [6:0] blk, input logic [6:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        drive_cycle(1'b1, {blk, off}, d, s, 1'b0, '0);
    endtask

    task automatic rd(input logic [6:0] blk, input logic [6:0] off);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, {blk, off});
    endtask

    // Monitor: independent of the driver, samples 1 time unit after each rising edge.
    task automatic monitor_step();
        rsp_t e;
        st_t  s;
        logic wexp, rexp;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            check("irq", irq, s.irq);
            check("reg_out", reg_out, s.regs);
        end
        wexp = (wq.size() > 0) && (wq[0].due == cyc);
        check("wack", wack, wexp);
        if (wexp) begin
            e = wq.pop_front();
            if (wack) begin
                check("werr", werr, e.err);
                check("wr_pulse", wr_pulse, e.pulse);
            end
        end else begin
            check("wr_pulse_idle", wr_pulse, 8'h0);
        end
        rexp = (rq.size() > 0) && (rq[0].due == cyc);
        check("rack", rack, rexp);
        if (rexp) begin
            e = rq.pop_front();
            if (rack) begin
                check("rerr", rerr, e.err);
                check("rdata", rdata, e.data);
            end
        end else begin
            check("rdata_idle", rdata, 32'h0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) monitor_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wack", wack, 1'b0);
        check("rst_rack", rack, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_reg_out", reg_out, 256'h0);
        check("rst_pulse", wr_pulse, 8'h0);
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;

        // Read every mapped offset after reset.
        for (int i = 0; i < NREGS; i++) rd(BASE, 7'(i));
        idle(1);

        // Byte strobes on reg0.
        wr(BASE, 7'd0, 32'hAABBCCDD, 4'hF);
        wr(BASE, 7'd0, 32'h11223344, 4'b0101);
        rd(BASE, 7'd0);
        idle(1);
        check("reg0_merge", m[0], 32'hAA22CC44);

        // W1C: set, clear collision, full clear.
        n_hset[5*32 +: 32] = 32'h9;
        idle(2);
        rd(BASE, 7'd5);
        n_hset[5*32 +: 32] = 32'h1;
        wr(BASE, 7'd5, 32'h1, 4'hF);
        rd(BASE, 7'd5);
        wr(BASE, 7'd5, 32'h9, 4'hF);
        rd(BASE, 7'd5);
        idle(2);

        // RO status register.
        n_hs[6*32 +: 32] = 32'hDEADBEEF;
        rd(BASE, 7'd6);
        wr(BASE, 7'd6, 32'h12345678, 4'hF);
        rd(BASE, 7'd6);
        wr(BASE, 7'd1, 32'hFFFF_FFFF, 4'h0);

        // Unmapped offset and foreign block.
        drive_cycle(1'b1, {BASE, 7'h08}, 32'hFFFFFFFF, 4'hF, 1'b1, {BASE, 7'h08});
        drive_cycle(1'b1, {7'h11, 7'h00}, 32'h5555AAAA, 4'hF, 1'b1, {7'h11, 7'h00});
        drive_cycle(1'b1, {BASE, 7'h7F}, 32'h1, 4'hF, 1'b1, {BASE, 7'h48});
        idle(1);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            logic [6:0] wb, rb, wo, ro;
            wb = ($urandom_range(0, 7) == 0) ? 7'h11 : BASE;
            rb = ($urandom_range(0, 7) == 0) ? 7'h0F : BASE;
            wo = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 9));
            ro = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 9));
            for (int i = 0; i < NREGS; i++) n_hs[32*i +: 32] = $urandom;
            n_hset[31:0] = $urandom;
            if ($urandom_range(0, 3) == 0) n_hset[5*32 +: 32] = $urandom & $urandom & $urandom;
            drive_cycle(1'($urandom), {wb, wo}, $urandom, 4'($urandom),
                        1'($urandom), {rb, ro});
        end
        idle(2);

        // Same-cycle write and read of reg1, then reset during an ack.
        wr(BASE, 7'd1, 32'h12345678, 4'hF);
        drive_cycle(1'b1, {BASE, 7'd1}, 32'hCAFEF00D, 4'hF, 1'b1, {BASE, 7'd1});
        rd(BASE, 7'd1);
        wr(BASE, 7'd1, 32'h00000055, 4'hF);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        mon_en = 1'b0;
        check("rstack_wack", wack, 1'b0);
        check("rstack_werr", werr, 1'b0);
        check("rstack_pulse", wr_pulse, 8'h0);
        check("rstack_reg1", reg_out[63:32], 32'h0);
        check("rstack_irq", irq, 1'b0);
        wreq = 1'b0;
        rreq = 1'b0;
        hset = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;
        rd(BASE, 7'd1);
        idle(3);

        check("wq_drained", 32'(wq.size()), 32'h0);
        check("rq_drained", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_reg_bank.md
Name: axi_reg_bank

Overview:
- Parametrised register bank on the 14-bit req/ack register bus.
- Upper address bits [13:7] select the block. Offset [6:0] selects one of NUM_REGS 32-bit registers.
- Each register is typed per index: read-write (RW), read-only hardware status (RO), or sticky write-1-to-clear event (W1C).
- Adds byte strobes, an error response for unmapped or illegal accesses, per-register write pulses, and an interrupt derived from the W1C bits.

Parameters:
- BASE_ADDRESS, 7'h10, block select matched against addr[13:7].
- NUM_REGS, 8, number of registers (1..128). Offsets 0..NUM_REGS-1 are mapped.
- RO_MASK, 128'h0C0, bit i=1 makes reg i read-only. Default: regs 6 and 7.
- W1C_MASK, 128'h020, bit i=1 makes reg i W1C. Default: reg 5. RO takes precedence where both masks are set.
- RESET_VALUE, 32'h0, reset value of every RW register.

Ports:
- axi_clk  in  1  clock
- axi_rstn  in  1  asynchronous active-low reset
- axi_wreq  in  1  write request, one-cycle pulse per access
- axi_waddr  in  14  write address
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte enables; bit b covers wdata[8b+7:8b]
- axi_wack  out  1  write acknowledge
- axi_werr  out  1  write error, valid with axi_wack
- axi_rreq  in  1  read request, one-cycle pulse per access
- axi_raddr  in  14  read address
- axi_rdata  out  32  read data, valid with axi_rack, 0 otherwise
- axi_rack  out  1  read acknowledge
- axi_rerr  out  1  read error, valid with axi_rack
- hw_status  in  NUM_REGS*32  RO source; slice i is reg i
- hw_set  in  NUM_REGS*32  W1C set pulses; slice i is reg i
- reg_out  out  NUM_REGS*32  storage of RW/W1C regs; RO slices drive 0
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is written successfully
- irq  out  1  OR of all W1C storage bits

Behaviour:
- Reset: axi_rstn low asynchronously forces the following, even mid-access:
  - axi_wack, axi_werr, axi_rack, axi_rerr, axi_rdata, reg_wr_pulse, irq = 0.
  - RW regs = RESET_VALUE; W1C regs = 0.
  - Any request pending at reset is dropped and never acked.
- Block select:
  - addr[13:7] != BASE_ADDRESS: request is ignored; no ack, no error, no state change.
  - Another block owns that address.
- Latency:
  - Ack, err and rdata are registered and valid exactly 1 cycle after the req cycle, for exactly 1 cycle.
  - Back-to-back reqs on consecutive cycles each produce their own ack.
- Write decode (selected block):
  - offset >= NUM_REGS: wack=1, werr=1, no state change.
  - RO reg: wack=1, werr=1, no state change, no pulse.
  - RW reg: each byte with wstrb[b]=1 takes wdata; other bytes hold. wack=1, werr=0.
  - W1C reg: each bit with wdata=1 and its byte strobe set clears. wack=1, werr=0.
  - wstrb=0 on RW/W1C: wack=1, werr=0, no change; reg_wr_pulse still fires.
  - reg_wr_pulse[i] asserts in the same cycle as wack for a successful write to reg i.
- W1C set:
  - hw_set bit=1 sets the storage bit on the next edge, independent of bus traffic.
  - Same-cycle set and clear on one bit: set wins (bit stays 1).
- irq: registered; updates one cycle after the W1C storage changes.
- Read decode (selected block):
  - offset >= NUM_REGS: rack=1, rerr=1, rdata=0.
  - RO reg: rdata = hw_status slice sampled in the req cycle.
  - RW/W1C reg: rdata = storage value in the req cycle, i.e. pre-write if a write to the same reg hits the same cycle.
  - Reads have no side effects.
- Concurrency: read and write channels are independent; both may be active in the same cycle.
- Width rules:
  - Offset compare uses the full 7 bits; no aliasing.
  - hw_status/hw_set/reg_out slice i occupies bits [32i+31:32i].

Test Plan:
1. Reset, then read offsets 0..7 at BASE 7'h10 -> rack=1 each, rdata=0, rerr=0; irq=0.
2. Write reg0 = 32'hAABBCCDD with wstrb=4'hF, then write 32'h11223344 with wstrb=4'b0101 -> read reg0 = 32'hAA22CC44; reg_wr_pulse[0] high 1 cycle per write.
3. hw_set slice5 = 32'h0000_0009 for 1 cycle -> reg5 = 9, irq=1 one cycle later. Write reg5 data 32'h1 with a concurrent hw_set bit0 pulse -> reg5 stays 9. Write 32'h9 -> reg5 = 0, then irq=0.
4. hw_status slice6 = 32'hDEADBEEF; read reg6 -> rdata = 32'hDEADBEEF. Write reg6 -> wack=1, werr=1, read still 32'hDEADBEEF, no pulse.
5. Write/read offset 7'h08 at BASE -> ack with err=1, rdata=0. Access at addr[13:7]=7'h11 -> no ack at all.
6. Write reg1 and read reg1 in the same cycle -> rdata = old value, next read = new value. Assert axi_rstn low during the ack cycle -> ack drops immediately, reg1 = RESET_VALUE.
